// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing with exception/interrupt/branch redirect
// priority, IF/ID pipeline register, and interrupt return-address capture.
module instruction_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstAddr,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JrTaken,
  input  logic [31:0] JrTarget,
  input  logic        Exception,
  input  logic        Irq,
  output logic [31:0] IfId_Instruction,
  output logic [31:0] IfId_PC4,
  output logic        IfId_Valid,
  output logic [31:0] Epc,
  output logic        IrqAck,
  output logic        Kernel
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_ack_q, irq_ack_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        irq_accept;
  logic        redirect;

  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    // Interrupts are masked in kernel space and yield to EX-stage redirects.
    irq_accept = Irq && !pc_q[31] && !Exception && !JrTaken && !BranchTaken;
    redirect   = Exception || irq_accept || JrTaken || BranchTaken || (Jump && !Stall);

    pc_target = pc_plus4;
    if (Exception)           pc_target = EXC_VEC;
    else if (irq_accept)     pc_target = IRQ_VEC;
    else if (JrTaken)        pc_target = JrTarget;
    else if (BranchTaken)    pc_target = BranchTarget;
    else if (Jump && !Stall) pc_target = JumpTarget;
    else if (Stall)          pc_target = pc_q;
    pc_d = pc_target & 32'hFFFF_FFFC;

    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect || Flush) begin
      // Bubble keeps the old PC4 so only the instruction/valid fields change.
      ifid_instr_d = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      ifid_instr_d = Instruction;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end

    epc_d     = irq_accept ? pc_q : epc_q;
    irq_ack_d = irq_accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VEC;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      epc_q        <= 32'd0;
      irq_ack_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      epc_q        <= epc_d;
      irq_ack_q    <= irq_ack_d;
    end
  end

  assign InstAddr         = pc_q;
  assign IfId_Instruction = ifid_instr_q;
  assign IfId_PC4         = ifid_pc4_q;
  assign IfId_Valid       = ifid_valid_q;
  assign Epc              = epc_q;
  assign IrqAck           = irq_ack_q;
  assign Kernel           = pc_q[31];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch;
  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] EV = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstAddr, Instruction;
  logic        Stall, Flush, Jump, BranchTaken, JrTaken, Exception, Irq;
  logic [31:0] JumpTarget, BranchTarget, JrTarget;
  logic [31:0] IfId_Instruction, IfId_PC4, Epc;
  logic        IfId_Valid, IrqAck, Kernel;

  instruction_fetch #(.RESET_VEC(RV), .IRQ_VEC(IV), .EXC_VEC(EV)) dut (
    .clk(clk), .reset(reset), .InstAddr(InstAddr), .Instruction(Instruction),
    .Stall(Stall), .Flush(Flush), .Jump(Jump), .JumpTarget(JumpTarget),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JrTaken(JrTaken), .JrTarget(JrTarget), .Exception(Exception), .Irq(Irq),
    .IfId_Instruction(IfId_Instruction), .IfId_PC4(IfId_PC4), .IfId_Valid(IfId_Valid),
    .Epc(Epc), .IrqAck(IrqAck), .Kernel(Kernel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign Instruction = imem(InstAddr);

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Literal expectations for the next compare edge
  logic        l_pc_en = 0, l_instr_en = 0, l_pc4_en = 0, l_valid_en = 0;
  logic        l_epc_en = 0, l_ack_en = 0, l_kern_en = 0;
  logic [31:0] l_pc, l_instr, l_pc4, l_epc;
  logic        l_valid, l_ack, l_kern;

  task automatic model_reset();
    m_pc = RV; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_ack = 0;
  endtask

  task automatic model_advance();
    logic        irq_ok, redir;
    logic [31:0] nxt;
    irq_ok = Irq && !m_pc[31] && !Exception && !JrTaken && !BranchTaken;
    redir  = 1'b1;
    if (Exception)           nxt = EV;
    else if (irq_ok)         nxt = IV;
    else if (JrTaken)        nxt = JrTarget;
    else if (BranchTaken)    nxt = BranchTarget;
    else if (Jump && !Stall) nxt = JumpTarget;
    else begin
      redir = 1'b0;
      nxt   = Stall ? m_pc : m_pc + 32'd4;
    end
    nxt = {nxt[31:2], 2'b00};
    if (redir || Flush) begin
      m_instr = 0; m_valid = 0;
    end else if (!Stall) begin
      m_instr = imem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    if (irq_ok) m_epc = m_pc;
    m_ack = irq_ok;
    m_pc  = nxt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("InstAddr", InstAddr, m_pc);
    chk("IfId_Instruction", IfId_Instruction, m_instr);
    chk("IfId_PC4", IfId_PC4, m_pc4);
    chk("IfId_Valid", {31'd0, IfId_Valid}, {31'd0, m_valid});
    chk("Epc", Epc, m_epc);
    chk("IrqAck", {31'd0, IrqAck}, {31'd0, m_ack});
    chk("Kernel", {31'd0, Kernel}, {31'd0, m_pc[31]});
    if (l_pc_en)    chk("lit_InstAddr", InstAddr, l_pc);
    if (l_instr_en) chk("lit_IfId_Instruction", IfId_Instruction, l_instr);
    if (l_pc4_en)   chk("lit_IfId_PC4", IfId_PC4, l_pc4);
    if (l_valid_en) chk("lit_IfId_Valid", {31'd0, IfId_Valid}, {31'd0, l_valid});
    if (l_epc_en)   chk("lit_Epc", Epc, l_epc);
    if (l_ack_en)   chk("lit_IrqAck", {31'd0, IrqAck}, {31'd0, l_ack});
    if (l_kern_en)  chk("lit_Kernel", {31'd0, Kernel}, {31'd0, l_kern});
    $display("cycle %0d rst_n=%0b pc=%08h ifid=%08h/%08h v=%0b epc=%08h ack=%0b",
             cyc, reset, InstAddr, IfId_Instruction, IfId_PC4, IfId_Valid, Epc, IrqAck);
  end

  task automatic idle();
    Stall = 0; Flush = 0; Jump = 0; BranchTaken = 0; JrTaken = 0; Exception = 0; Irq = 0;
    JumpTarget = 0; BranchTarget = 0; JrTarget = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_advance();
    cyc++;
    @(negedge clk);
    #1;
    l_pc_en = 0; l_instr_en = 0; l_pc4_en = 0; l_valid_en = 0;
    l_epc_en = 0; l_ack_en = 0; l_kern_en = 0;
  endtask

  task automatic e_pc(input logic [31:0] v);    l_pc_en = 1;    l_pc = v;    endtask
  task automatic e_instr(input logic [31:0] v); l_instr_en = 1; l_instr = v; endtask
  task automatic e_pc4(input logic [31:0] v);   l_pc4_en = 1;   l_pc4 = v;   endtask
  task automatic e_valid(input logic v);        l_valid_en = 1; l_valid = v; endtask
  task automatic e_epc(input logic [31:0] v);   l_epc_en = 1;   l_epc = v;   endtask
  task automatic e_ack(input logic v);          l_ack_en = 1;   l_ack = v;   endtask
  task automatic e_kern(input logic v);         l_kern_en = 1;  l_kern = v;  endtask

  initial begin
    reset = 0;
    idle();
    model_reset();
    // Reset values, then release and free-run from RESET_VEC
    e_pc(RV); e_instr(0); e_pc4(0); e_valid(0); e_epc(0); e_ack(0); e_kern(1);
    step(); step();
    reset = 1;
    e_pc(RV + 4); e_valid(1); e_instr(imem(RV)); e_pc4(RV + 4);
    step();
    e_pc(RV + 8); step();
    // Jump with unaligned target, then stall at 0x10
    Jump = 1; JumpTarget = 32'h0000_000F; e_pc(32'h0C); e_valid(0); step();
    idle(); e_pc(32'h10); e_valid(1); e_instr(imem(32'h0C)); e_pc4(32'h10); e_kern(0); step();
    Stall = 1; e_pc(32'h10); e_instr(imem(32'h0C)); e_pc4(32'h10); e_valid(1); step();
    e_pc(32'h10); e_instr(imem(32'h0C)); e_pc4(32'h10); step();
    idle(); e_pc(32'h14); e_instr(imem(32'h10)); e_pc4(32'h14); step();
    // Branch overrides stall
    Stall = 1; BranchTaken = 1; BranchTarget = 32'h40; e_pc(32'h40); e_valid(0); step();
    // Interrupt from user space at 0x20
    idle(); Jump = 1; JumpTarget = 32'h20; e_pc(32'h20); step();
    idle(); Irq = 1; e_pc(IV); e_epc(32'h20); e_ack(1); e_valid(0); step();
    e_pc(IV + 4); e_ack(0); step();
    Jump = 1; JumpTarget = 32'h8000_0010; e_pc(32'h8000_0010); e_ack(0); step();
    Jump = 0; e_pc(32'h8000_0014); e_ack(0); e_epc(32'h20); step();
    // Exception beats interrupt and Jr; interrupt taken later in user mode
    idle(); Jump = 1; JumpTarget = 32'h30; step();
    idle(); Exception = 1; Irq = 1; JrTaken = 1; JrTarget = 32'h50;
    e_pc(EV); e_ack(0); e_valid(0); step();
    idle(); Irq = 1; Jump = 1; JumpTarget = 32'h60; e_pc(32'h60); e_ack(0); step();
    idle(); Irq = 1; e_pc(IV); e_ack(1); e_epc(32'h60); step();
    // PC wrap out of kernel space
    idle(); Jump = 1; JumpTarget = 32'hFFFF_FFFC; e_pc(32'hFFFF_FFFC); e_kern(1); step();
    idle(); e_pc(0); e_kern(0); e_pc4(0); e_valid(1); e_instr(imem(32'hFFFF_FFFC)); step();
    // Flush wins over stall
    Stall = 1; Flush = 1; e_pc(0); e_valid(0); e_instr(0); e_pc4(0); step();
    // Reset during a pending jump
    idle(); Jump = 1; JumpTarget = 32'h100;
    #2 reset = 0;
    model_reset();
    e_pc(RV); e_instr(0); e_pc4(0); e_valid(0); e_epc(0); e_ack(0);
    step();
    reset = 1; idle(); e_pc(RV + 4); e_valid(1); step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 199) == 0) begin
        reset = 0;
        model_reset();
        step();
        reset = 1;
        continue;
      end
      Stall       = ($urandom_range(0, 99) < 20);
      Flush       = ($urandom_range(0, 99) < 10);
      Jump        = ($urandom_range(0, 99) < 15);
      BranchTaken = ($urandom_range(0, 99) < 10);
      JrTaken     = ($urandom_range(0, 99) < 7);
      Exception   = ($urandom_range(0, 99) < 4);
      Irq         = ($urandom_range(0, 99) < 20);
      t = $urandom; if ($urandom_range(0, 3) != 0) t[31] = 1'b0; JumpTarget = t;
      t = $urandom; if ($urandom_range(0, 3) != 0) t[31] = 1'b0; BranchTarget = t;
      t = $urandom; if ($urandom_range(0, 3) != 0) t[31] = 1'b0; JrTarget = t;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VEC, default 32'h80000000, PC value loaded on reset.
REQ-002 Parameter IRQ_VEC, default 32'h80000004, interrupt entry address.
REQ-003 Parameter EXC_VEC, default 32'h80000008, exception entry address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 InstAddr  output  32  current PC, drives the combinational instruction memory address.
REQ-007 Instruction  input  32  instruction word returned for InstAddr in the same cycle.
REQ-008 Stall  input  1  hold PC and IF/ID register (load-use hazard).
REQ-009 Flush  input  1  replace IF/ID contents with a bubble.
REQ-010 Jump, JumpTarget  input  1/32  unconditional redirect resolved in ID.
REQ-011 BranchTaken, BranchTarget  input  1/32  taken branch resolved in EX.
REQ-012 JrTaken, JrTarget  input  1/32  register jump resolved in EX.
REQ-013 Exception  input  1  synchronous exception request from a later stage.
REQ-014 Irq  input  1  level-sensitive external interrupt request.
REQ-015 IfId_Instruction  output  32  registered instruction to ID.
REQ-016 IfId_PC4  output  32  registered PC+4 of that instruction.
REQ-017 IfId_Valid  output  1  registered: IF/ID holds a real instruction.
REQ-018 Epc  output  32  registered return address captured on interrupt entry.
REQ-019 IrqAck  output  1  registered one-cycle pulse: interrupt accepted.
REQ-020 Kernel  output  1  combinational, equals PC[31].

Function
REQ-021 Next-PC priority, highest first: Exception -> EXC_VEC; accepted Irq -> IRQ_VEC; JrTaken -> JrTarget; BranchTaken -> BranchTarget; Jump and not Stall -> JumpTarget; Stall -> hold; else PC+4.
REQ-022 Irq accepted only when Irq=1, PC[31]=0, and no Exception, JrTaken or BranchTaken in the same cycle; otherwise deferred while Irq stays high.
REQ-023 Irq accepted while PC[31]=1 never; request remains pending until PC[31]=0.
REQ-024 On Irq acceptance: Epc <= current PC, IrqAck <= 1 for exactly one cycle.
REQ-025 Any redirect (Exception, accepted Irq, JrTaken, BranchTaken, Jump not stalled) loads IF/ID with bubble: IfId_Instruction=0, IfId_Valid=0, IfId_PC4 unchanged.
REQ-026 Flush=1 loads the IF/ID bubble regardless of Stall; PC still follows REQ-021.
REQ-027 Stall=1 with no redirect and no Flush: PC, IF/ID, Epc all hold values.
REQ-028 Normal cycle: IfId_Instruction <= Instruction, IfId_PC4 <= PC+4, IfId_Valid <= 1.
REQ-029 PC+4 arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 and clears Kernel.
REQ-030 Latency: a redirect asserted in cycle N gives InstAddr=target in cycle N+1; the first target instruction appears in IF/ID in cycle N+2.
REQ-031 PC[1:0] forced to 2'b00 on every load; target low bits ignored.
REQ-032 No internal state beyond PC, IF/ID fields, Epc, IrqAck.

Reset
REQ-033 While reset=0 (asynchronous): PC=RESET_VEC, IfId_Instruction=0, IfId_PC4=0, IfId_Valid=0, Epc=0, IrqAck=0.
REQ-034 Reset asserted mid-operation discards any pending redirect or interrupt; first fetch after release is RESET_VEC.
REQ-035 First rising edge after reset release performs a normal cycle from RESET_VEC (Kernel=1).

Verification
REQ-036 Reset, release, no stimulus -> InstAddr 80000000, 80000004, 80000008 on successive cycles; IfId_Valid rises one cycle after release.
REQ-037 PC=00000010, Stall=1 two cycles -> InstAddr stays 00000010, IF/ID unchanged; Stall=0 -> 00000014.
REQ-038 Stall=1 and BranchTaken=1, BranchTarget=00000040 same cycle -> InstAddr 00000040 next cycle, IfId_Valid=0.
REQ-039 PC=00000020, Irq=1 -> InstAddr 80000004, Epc=00000020, IrqAck pulses one cycle; Irq held at PC=80000010 -> no acceptance.
REQ-040 Exception=1 and Irq=1 and JrTaken=1 together -> InstAddr 80000008, IrqAck=0; Irq accepted on a later user-mode cycle.
REQ-041 Reset asserted during Jump to 00000100 -> InstAddr 80000000 immediately, all IF/ID outputs 0.
